// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared types and the round-robin pick function for the memory arbiter
package avalon_arb_pkg;

    localparam int MAX_REQ     = 32;
    localparam int MAX_IDWIDTH = 5;

    typedef struct packed {
        logic                   valid;
        logic [MAX_IDWIDTH-1:0] id;
    } id_pipe_entry_t;

    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]     active,
        input logic [MAX_IDWIDTH-1:0] ptr,
        input int                     n
    );
        logic [MAX_REQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (g == '0 && active[idx[MAX_IDWIDTH-1:0]]) g[idx[MAX_IDWIDTH-1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered priority pointer
module rr_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDWIDTH = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] active,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDWIDTH-1:0] grant_id,
    output logic               any_grant,
    output logic [IDWIDTH-1:0] ptr
);

    logic [MAX_REQ-1:0] pick;

    // Search from ptr upward with wrap; nothing is granted while reset is held
    always_comb begin
        pick      = rr_pick(MAX_REQ'(active), MAX_IDWIDTH'(ptr), NUM_REQ);
        grant     = reset ? '0 : pick[NUM_REQ-1:0];
        grant_id  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) grant_id = IDWIDTH'(i);
        any_grant = |grant;
    end

    // Pointer moves just past the winner; explicit wrap keeps non-power-of-2 counts legal
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (any_grant)
            ptr <= (grant_id == IDWIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

endmodule

// File: rtl/avalon_memory_arbiter.sv
// avalon_memory_arbiter: round-robin sharing of one Avalon block-RAM adapter port
module avalon_memory_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSWIDTH     = 32,
    parameter int ADDRESSWIDTH = 8,
    parameter int LATENCY      = 1,
    parameter int IDWIDTH      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_address,
    input  logic [NUM_REQ*BUSWIDTH-1:0]     req_data_in,
    output logic [NUM_REQ-1:0]              req_waitrequest,
    output logic [NUM_REQ-1:0]              req_read_valid,
    output logic [BUSWIDTH-1:0]             req_data_out,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDRESSWIDTH-1:0]         mem_address,
    output logic [BUSWIDTH-1:0]             mem_data_in,
    input  logic                            mem_read_valid,
    input  logic [BUSWIDTH-1:0]             mem_data_out,
    output logic                            protocol_error
);

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant;
    logic [IDWIDTH-1:0] grant_id;
    logic [IDWIDTH-1:0] ptr;
    logic [IDWIDTH-1:0] sel;
    logic               any_grant;
    logic               both;
    id_pipe_entry_t     pipe [LATENCY];
    id_pipe_entry_t     tail;

    assign active = req_read | req_write;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDWIDTH (IDWIDTH)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant),
        .ptr       (ptr)
    );

    // Route the granted slice to the adapter; a simultaneous read+write issues only the write
    always_comb begin
        sel             = any_grant ? grant_id : ptr;
        mem_address     = req_address[sel*ADDRESSWIDTH +: ADDRESSWIDTH];
        mem_data_in     = req_data_in[sel*BUSWIDTH +: BUSWIDTH];
        both            = any_grant & req_read[grant_id] & req_write[grant_id];
        mem_write       = any_grant & req_write[grant_id];
        mem_read        = any_grant & req_read[grant_id] & ~req_write[grant_id];
        req_waitrequest = active & ~grant;
        tail            = pipe[LATENCY-1];
        req_read_valid  = tail.valid ? NUM_REQ'(1) << tail.id : '0;
        req_data_out    = mem_data_out;
    end

    // ID pipe tracks which requester owns each outstanding read; it never stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: mem_read, id: MAX_IDWIDTH'(grant_id)};
            for (int i = 1; i < LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    // Sticky error on an illegal read+write or a read_valid that disagrees with the pipe tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            protocol_error <= 1'b0;
        else if (both || (mem_read_valid != tail.valid))
            protocol_error <= 1'b1;
    end

endmodule

// File: tb/tb_avalon_memory_arbiter.sv
// tb_avalon_memory_arbiter: directed checks of grant order, read routing and error flag
module tb_avalon_memory_arbiter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        req_read = '0;
    logic [3:0]        req_write = '0;
    logic [3:0][7:0]   addr = '0;
    logic [3:0][31:0]  wdata = '0;
    logic [3:0]        req_waitrequest;
    logic [3:0]        req_read_valid;
    logic [31:0]       req_data_out;
    logic              mem_read;
    logic              mem_write;
    logic [7:0]        mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_read_valid;
    logic [31:0]       mem_data_out;
    logic              protocol_error;
    logic              inject = 1'b0;
    logic [1:0]        rv;
    logic [1:0][7:0]   ap;
    int                checks = 0;
    int                failures = 0;

    avalon_memory_arbiter #(
        .NUM_REQ      (4),
        .BUSWIDTH     (32),
        .ADDRESSWIDTH (8),
        .LATENCY      (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_address     (addr),
        .req_data_in     (wdata),
        .req_waitrequest (req_waitrequest),
        .req_read_valid  (req_read_valid),
        .req_data_out    (req_data_out),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_read_valid  (mem_read_valid),
        .mem_data_out    (mem_data_out),
        .protocol_error  (protocol_error)
    );

    always #5 clk = ~clk;

    // Adapter model: two-cycle read latency, data = 0xA5A5_0000 | address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv <= '0;
            ap <= '0;
        end else begin
            rv <= {rv[0], mem_read};
            ap <= {ap[0], mem_address};
        end
    end

    assign mem_read_valid = rv[1] | inject;
    assign mem_data_out   = 32'hA5A5_0000 | {24'h0, ap[1]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_read = '0;
        req_write = '0;
        inject = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // reset state: waitrequest mirrors active, nothing issued
        req_read = 4'b1010;
        tick();
        #1;
        check("rst_wait", 32'(req_waitrequest), 32'h0000_000A);
        check("rst_mrd", 32'(mem_read), 32'h0);
        check("rst_rv", 32'(req_read_valid), 32'h0);
        check("rst_perr", 32'(protocol_error), 32'h0);
        check("rst_ptr", 32'(dut.u_arb.ptr), 32'h0);
        do_reset();

        // 1. single read from requester 2
        req_read = 4'b0100;
        addr[2] = 8'h10;
        #1;
        check("t1_wait", 32'(req_waitrequest), 32'h0);
        check("t1_mrd", 32'(mem_read), 32'h1);
        check("t1_addr", 32'(mem_address), 32'h10);
        tick();
        req_read = '0;
        #1;
        check("t1_ptr", 32'(dut.u_arb.ptr), 32'h3);
        check("t1_rv_c1", 32'(req_read_valid), 32'h0);
        tick();
        #1;
        check("t1_rv_c2", 32'(req_read_valid), 32'h4);
        check("t1_data", req_data_out, 32'hA5A5_0010);
        tick();
        #1;
        check("t1_rv_c3", 32'(req_read_valid), 32'h0);

        // 2. all four read continuously
        do_reset();
        for (int i = 0; i < 4; i++) addr[i] = 8'(i);
        req_read = 4'hF;
        for (int k = 0; k < 7; k++) begin
            #1;
            check($sformatf("t2_wait%0d", k), 32'(req_waitrequest), 32'(~(4'b1 << (k % 4)) & 4'hF));
            check($sformatf("t2_rv%0d", k), 32'(req_read_valid), k >= 2 ? 32'(4'b1 << ((k - 2) % 4)) : 32'h0);
            if (k >= 2)
                check($sformatf("t2_data%0d", k), req_data_out, 32'hA5A5_0000 | 32'((k - 2) % 4));
            tick();
        end
        req_read = '0;

        // 3. write from 1 and read from 3 together
        do_reset();
        req_write = 4'b0010;
        addr[1] = 8'h03;
        wdata[1] = 32'hDEAD_BEEF;
        req_read = 4'b1000;
        addr[3] = 8'h20;
        #1;
        check("t3_mwr", 32'(mem_write), 32'h1);
        check("t3_mrd0", 32'(mem_read), 32'h0);
        check("t3_addr0", 32'(mem_address), 32'h03);
        check("t3_wdata", mem_data_in, 32'hDEAD_BEEF);
        check("t3_wait0", 32'(req_waitrequest), 32'h8);
        tick();
        req_write = '0;
        #1;
        check("t3_mrd1", 32'(mem_read), 32'h1);
        check("t3_addr1", 32'(mem_address), 32'h20);
        check("t3_wait1", 32'(req_waitrequest), 32'h0);
        tick();
        req_read = '0;
        #1;
        check("t3_rv2", 32'(req_read_valid), 32'h0);
        tick();
        #1;
        check("t3_rv3", 32'(req_read_valid), 32'h8);
        check("t3_data", req_data_out, 32'hA5A5_0020);
        check("t3_perr", 32'(protocol_error), 32'h0);

        // 4. read and write together on one requester
        do_reset();
        req_read = 4'b0001;
        req_write = 4'b0001;
        addr[0] = 8'h07;
        #1;
        check("t4_mwr", 32'(mem_write), 32'h1);
        check("t4_mrd", 32'(mem_read), 32'h0);
        check("t4_addr", 32'(mem_address), 32'h07);
        check("t4_wait", 32'(req_waitrequest), 32'h0);
        tick();
        req_read = '0;
        req_write = '0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check($sformatf("t4_perr%0d", k), 32'(protocol_error), 32'h1);
            check($sformatf("t4_rv%0d", k), 32'(req_read_valid), 32'h0);
            tick();
        end

        // 5. reset right after a read is accepted
        do_reset();
        req_read = 4'b0010;
        addr[1] = 8'h05;
        tick();
        req_read = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t5_rv%0d", k), 32'(req_read_valid), 32'h0);
            check($sformatf("t5_ptr%0d", k), 32'(dut.u_arb.ptr), 32'h0);
            check($sformatf("t5_perr%0d", k), 32'(protocol_error), 32'h0);
            tick();
        end

        // 6. spurious read_valid from the adapter
        do_reset();
        inject = 1'b1;
        #1;
        check("t6_perr_pre", 32'(protocol_error), 32'h0);
        tick();
        inject = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("t6_perr%0d", k), 32'(protocol_error), 32'h1);
            check($sformatf("t6_rv%0d", k), 32'(req_read_valid), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
